uart_tx: RTL and testbench

UART transmitter that serialises bytes onto a single TX line (8N1, LSB first). It is the counterpart to the existing UART receiver in the WSPR toplevel. It lets the design return status and echo bytes, such as the current symbol index and the encoding-valid flag, to the host that loads messages over `rx`. A byte-level valid/ready handshake feeds it, and its output drives a dedicated output pin.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_if.sv | 26 ++
 rtl/uart_baud_tick.sv | 41 ++++
 rtl/uart_tx.sv | 114 +++++++++++
 tb/tb_uart_tx.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_pkg: shared UART frame constants, FSM states and rate helper.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    // Whole clock cycles per serial bit; any remainder is dropped.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_tx_if: byte-level valid/ready handshake into the transmitter.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface uart_tx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] data;
    logic                      data_valid;
    logic                      data_ready;

    modport master (
        output data,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data,
        input  data_valid,
        output data_ready
    );

endinterface
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_baud_tick: bit-period counter, one-cycle tick on last cycle.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int                CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_rate
            $error("uart_baud_tick: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_LAST);
    assign tick   = w_last && !clear;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_tx: 8N1 LSB-first serial transmitter with valid/ready input.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 10_000_000,
    parameter int BAUD     = 9600
) (
    input  logic     clk,
    input  logic     reset,
    uart_tx_if.slave s_if,
    output logic     tx,
    output logic     busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t            r_state;
    uart_tx_state_t            w_state_nxt;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] w_shift_nxt;
    logic [2:0]                r_bit_idx;
    logic [2:0]                w_bit_idx_nxt;
    logic                      r_tx;
    logic                      w_tx_nxt;
    logic                      r_armed;
    logic                      w_accept;
    logic                      w_tick;
    logic                      w_baud_clear;

    // Holding the counter clear while idle makes every frame start at count 0.
    assign w_baud_clear = (r_state == IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .clear (w_baud_clear),
        .tick  (w_tick)
    );

    // r_armed delays readiness one cycle after reset release.
    assign s_if.data_ready = (r_state == IDLE) && r_armed && reset;
    assign w_accept        = s_if.data_valid && s_if.data_ready;
    assign busy            = (r_state != IDLE);
    assign tx              = r_tx;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
            r_armed   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_tx      <= w_tx_nxt;
            r_armed   <= 1'b1;
        end
    end

    // Line level is computed from the current state and registered, so tx
    // trails the state by one cycle and never glitches.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        w_tx_nxt      = 1'b1;
        unique case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_accept) begin
                    w_shift_nxt   = s_if.data;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = START;
                end
            end
            START: begin
                w_tx_nxt = 1'b0;
                if (w_tick) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                w_tx_nxt = r_shift[0];
                if (w_tick) begin
                    w_shift_nxt   = {1'b0, r_shift[UART_DATA_BITS-1:1]};
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == LAST_BIT) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                w_tx_nxt = 1'b1;
                if (w_tick) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_uart_tx: randomized self-checking bench for uart_tx (C = 4).     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_uart_tx;
    import uart_pkg::*;

    localparam int C     = 4;
    localparam int FRAME = 10 * C;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic tx;
    logic busy;

    uart_tx_if ifc ();

    uart_tx #(
        .CLK_FREQ (16),
        .BAUD     (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .s_if  (ifc),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edges  = 0;

    // Histories indexed by posedge number: entry e holds the value after edge e.
    logic tx_hist[$];
    logic busy_hist[$];
    logic rdy_hist[$];
    int   acc_q[$];

    always @(posedge clk) begin
        if (reset && ifc.data_valid && ifc.data_ready) acc_q.push_back(edges);
        edges <= edges + 1;
    end

    always @(negedge clk) begin
        tx_hist.push_back(tx);
        busy_hist.push_back(busy);
        rdy_hist.push_back(ifc.data_ready);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: 10 slots of C cycles each: start 0, data LSB first, stop 1.
    function automatic logic [FRAME-1:0] model_frame(input logic [7:0] d);
        logic [9:0]       slots;
        logic [FRAME-1:0] f;
        slots = {1'b1, d, 1'b0};
        for (int j = 0; j < FRAME; j++) f[j] = slots[j / C];
        return f;
    endfunction

    function automatic logic [FRAME-1:0] tx_window(input int a);
        logic [FRAME-1:0] w;
        for (int j = 0; j < FRAME; j++) w[j] = tx_hist[a + 1 + j];
        return w;
    endfunction

    task automatic wait_hist(input int e);
        for (int i = 0; i < 2000 && tx_hist.size() <= e + 1; i++) @(negedge clk);
    endtask

    task automatic send_pulse(input logic [7:0] d, output int a, output bit ok);
        int n0;
        n0             = acc_q.size();
        ifc.data       = d;
        ifc.data_valid = 1'b1;
        ok             = 1'b0;
        a              = -1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (acc_q.size() > n0) ok = 1'b1;
        end
        ifc.data_valid = 1'b0;
        if (ok) a = acc_q[n0];
    endtask

    task automatic test_reset;
        int r;
        reset          = 1'b0;
        ifc.data_valid = 1'b0;
        ifc.data       = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (ifc.data_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ifc.data_ready); end
        reset = 1'b1;
        r     = edges;
        @(negedge clk);
        checks++;
        if (ifc.data_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1 (edge %0d)", ifc.data_ready, r); end
    endtask

    task automatic test_single;
        int a;
        int bcnt;
        bit ok;
        send_pulse(8'hA5, a, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_accept: got none want 1"); return; end
        wait_hist(a + FRAME + 2);
        checks++;
        if (tx_hist[a] !== 1'b1) begin errors++; $display("FAIL single_latency: tx after accept edge %b want 1", tx_hist[a]); end
        checks++;
        if (tx_window(a) !== model_frame(8'hA5))
            begin errors++; $display("FAIL single_frame: got %h want %h", tx_window(a), model_frame(8'hA5)); end
        bcnt = 0;
        for (int e = a - 1; e <= a + FRAME + 1; e++) if (busy_hist[e] === 1'b1) bcnt++;
        checks++;
        if (bcnt != FRAME) begin errors++; $display("FAIL single_busy: got %0d cycles want %0d", bcnt, FRAME); end
        checks++;
        if (rdy_hist[a + FRAME] !== 1'b1) begin errors++; $display("FAIL single_ready_back: got %b want 1", rdy_hist[a + FRAME]); end
    endtask

    task automatic test_back_to_back;
        int n0;
        int a0;
        int a1;
        n0             = acc_q.size();
        ifc.data       = 8'h00;
        ifc.data_valid = 1'b1;
        for (int i = 0; i < 100 && acc_q.size() < n0 + 1; i++) @(negedge clk);
        ifc.data = 8'hFF;
        for (int i = 0; i < 100 && acc_q.size() < n0 + 2; i++) @(negedge clk);
        ifc.data_valid = 1'b0;
        checks++;
        if (acc_q.size() < n0 + 2) begin errors++; $display("FAIL b2b_accepts: got %0d want 2", acc_q.size() - n0); return; end
        a0 = acc_q[n0];
        a1 = acc_q[n0 + 1];
        wait_hist(a1 + FRAME + 2);
        checks++;
        if (a1 - a0 != FRAME + 1) begin errors++; $display("FAIL b2b_period: got %0d want %0d", a1 - a0, FRAME + 1); end
        checks++;
        if ({tx_hist[a0 + FRAME], tx_hist[a0 + FRAME + 1], tx_hist[a0 + FRAME + 2]} !== 3'b110)
            begin errors++; $display("FAIL b2b_idle_gap: got %b%b%b want 110", tx_hist[a0 + FRAME], tx_hist[a0 + FRAME + 1], tx_hist[a0 + FRAME + 2]); end
        checks++;
        if (tx_window(a0) !== model_frame(8'h00)) begin errors++; $display("FAIL b2b_frame0: got %h want %h", tx_window(a0), model_frame(8'h00)); end
        checks++;
        if (tx_window(a1) !== model_frame(8'hFF)) begin errors++; $display("FAIL b2b_frame1: got %h want %h", tx_window(a1), model_frame(8'hFF)); end
    endtask

    task automatic test_handshake_ignore;
        int  a;
        int  n0;
        int  bad;
        bit  ok;
        n0 = acc_q.size();
        send_pulse(8'h3C, a, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL hs_accept: got none want 1"); return; end
        while (edges < a + FRAME - 6) begin
            ifc.data_valid = 1'($urandom_range(0, 1));
            ifc.data       = 8'($urandom);
            @(negedge clk);
        end
        ifc.data_valid = 1'b0;
        wait_hist(a + FRAME + 20);
        checks++;
        if (acc_q.size() != n0 + 1) begin errors++; $display("FAIL hs_extra_frame: got %0d accepts want 1", acc_q.size() - n0); end
        checks++;
        if (tx_window(a) !== model_frame(8'h3C)) begin errors++; $display("FAIL hs_frame: got %h want %h", tx_window(a), model_frame(8'h3C)); end
        bad = 0;
        for (int e = a + FRAME + 1; e <= a + FRAME + 18; e++) if (tx_hist[e] !== 1'b1) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL hs_idle_after: got %0d low samples want 0", bad); end
    endtask

    task automatic test_reset_midframe;
        int a;
        int a2;
        bit ok;
        send_pulse(8'h81, a, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_mid_accept: got none want 1"); return; end
        while (edges < a + 1 + 4 * C + 2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx, busy, ifc.data_ready} !== 3'b100)
            begin errors++; $display("FAIL rst_mid_state: tx/busy/ready got %b%b%b want 100", tx, busy, ifc.data_ready); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (ifc.data_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", ifc.data_ready); end
        send_pulse(8'h81, a2, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_mid_reaccept: got none want 1"); return; end
        wait_hist(a2 + FRAME + 2);
        checks++;
        if (tx_window(a2) !== model_frame(8'h81)) begin errors++; $display("FAIL rst_mid_frame: got %h want %h", tx_window(a2), model_frame(8'h81)); end
    endtask

    task automatic test_reset_valid_held;
        int         n0;
        int         s;
        int         r;
        int         a;
        int         lows;
        logic [7:0] d;
        d              = 8'($urandom);
        n0             = acc_q.size();
        reset          = 1'b0;
        ifc.data       = d;
        ifc.data_valid = 1'b1;
        s              = edges;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        r     = edges;
        for (int i = 0; i < 20 && acc_q.size() < n0 + 1; i++) @(negedge clk);
        ifc.data_valid = 1'b0;
        checks++;
        if (acc_q.size() != n0 + 1) begin errors++; $display("FAIL rvh_accepts: got %0d want 1", acc_q.size() - n0); return; end
        a = acc_q[n0];
        wait_hist(a + FRAME + 2);
        lows = 0;
        for (int e = s; e < r; e++) if (tx_hist[e] !== 1'b1) lows++;
        checks++;
        if (lows != 0) begin errors++; $display("FAIL rvh_tx_in_reset: got %0d low samples want 0", lows); end
        checks++;
        if (a != r + 1) begin errors++; $display("FAIL rvh_accept_edge: got r+%0d want r+1", a - r); end
        checks++;
        if ({tx_hist[r], tx_hist[r + 1], tx_hist[r + 2]} !== 3'b110)
            begin errors++; $display("FAIL rvh_start_edge: got %b%b%b want 110", tx_hist[r], tx_hist[r + 1], tx_hist[r + 2]); end
        checks++;
        if (tx_window(a) !== model_frame(d)) begin errors++; $display("FAIL rvh_frame: got %h want %h", tx_window(a), model_frame(d)); end
    endtask

    task automatic test_idle_line;
        int bad;
        int n0;
        ifc.data_valid = 1'b0;
        reset          = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n0    = acc_q.size();
        bad   = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || acc_q.size() != n0)
            begin errors++; $display("FAIL idle_line: got %0d bad samples, %0d accepts want 0/0", bad, acc_q.size() - n0); end
    endtask

    task automatic test_random_bytes;
        int         a[6];
        logic [7:0] d[6];
        bit         ok;
        for (int i = 0; i < 6; i++) begin
            d[i] = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_pulse(d[i], a[i], ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL rand_accept%0d: got none want 1", i); return; end
        end
        wait_hist(a[5] + FRAME + 2);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (tx_window(a[i]) !== model_frame(d[i]))
                begin errors++; $display("FAIL rand_frame%0d: byte %h got %h want %h", i, d[i], tx_window(a[i]), model_frame(d[i])); end
        end
    endtask

    initial begin
        ifc.data       = 8'h00;
        ifc.data_valid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_handshake_ignore();
        test_reset_midframe();
        test_reset_valid_held();
        test_idle_line();
        test_random_bytes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
